// File: rtl/led_pkg.sv
// Shared constants and types for the LED PWM driver and its timebase.
package led_pkg;

    localparam int NUM_LEDS         = 8;
    localparam int DUTY_W           = 8;
    localparam int CHAN_W           = 3;
    localparam int PRESCALE_DEFAULT = 195;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [CHAN_W-1:0] chan_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and 8-bit PWM phase counter; tick marks each step, wrap marks phase 255 -> 0.
module pwm_timebase
    import led_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic  clk_50mhz,
    input  logic  rst,
    output logic  tick,
    output duty_t phase,
    output logic  wrap
);

    localparam int PS_W = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

    logic [PS_W-1:0] presc;

    assign tick = (presc == PS_W'(PRESCALE));
    assign wrap = tick && (phase == '1);

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            presc <= '0;
            phase <= '0;
        end else if (tick) begin
            presc <= '0;
            phase <= phase + duty_t'(1);
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// Eight-channel active-low LED PWM driver with double-buffered duty registers
// that only take effect at frame boundaries.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic                clk_50mhz,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic [DUTY_W-1:0]   wr_duty,
    output logic [NUM_LEDS-1:0] led,
    output logic                frame_start
);

    logic                tick;
    logic                wrap;
    duty_t               phase;
    duty_t               phase_next;
    duty_t               pending     [NUM_LEDS];
    duty_t               active      [NUM_LEDS];
    duty_t               active_next [NUM_LEDS];
    logic [NUM_LEDS-1:0] dirty;
    logic [NUM_LEDS-1:0] led_next;
    logic                wr_fire;

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .tick      (tick),
        .phase     (phase),
        .wrap      (wrap)
    );

    // The commit cycle is the wrap cycle; blocking writes there keeps pending stable while it is copied.
    assign wr_ready   = !rst && !wrap;
    assign wr_fire    = wr_valid && wr_ready;
    assign phase_next = tick ? phase + duty_t'(1) : phase;

    // The LED register is fed from post-edge phase/duty so the lamp tracks the phase register exactly.
    always_comb begin
        led_next = '1;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            active_next[i] = (wrap && dirty[i]) ? pending[i] : active[i];
            led_next[i]    = !(phase_next < active_next[i]);
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
            dirty       <= '0;
            led         <= '1;
            frame_start <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                active[i] <= active_next[i];
            end
            if (wrap) begin
                dirty <= '0;
            end
            if (wr_fire) begin
                pending[wr_chan] <= wr_duty;
                dirty[wr_chan]   <= 1'b1;
            end
            led         <= led_next;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver with PRESCALE=3 (1024-cycle frames).
module tb_led_pwm_driver;

    localparam int FRAME = 1024;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_chan;
    logic [7:0] wr_duty;
    logic [7:0] led;
    logic       frame_start;

    led_pwm_driver #(
        .PRESCALE (3)
    ) dut (
        .clk_50mhz   (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_chan     (wr_chan),
        .wr_duty     (wr_duty),
        .led         (led),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] led;
        logic       fs;
        logic       ready;
    } exp_t;

    typedef struct {
        int ch;
        int duty;
        int exp_lit;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc;
    logic [7:0] mpend[8];
    logic [7:0] mact[8];
    logic [7:0] mdirty;
    int         lit_cnt[8];
    int         ncyc;
    int         stalls;
    int         guard;
    int         sum;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (model cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Timeline model: state is a function of cycles since reset plus committed duties.
    task automatic model_edge();
        if (rst) begin
            cyc = 0;
            mdirty = '0;
            for (int i = 0; i < 8; i++) begin
                mpend[i] = '0;
                mact[i]  = '0;
            end
        end else begin
            bit acc;
            acc = wr_valid && (cyc % FRAME != FRAME - 1);
            if (cyc % FRAME == FRAME - 1) begin
                for (int i = 0; i < 8; i++) begin
                    if (mdirty[i]) mact[i] = mpend[i];
                end
                mdirty = '0;
            end
            if (acc) begin
                mpend[wr_chan]  = wr_duty;
                mdirty[wr_chan] = 1'b1;
            end
            cyc++;
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        int   ph;
        ph = (cyc / 4) % 256;
        for (int i = 0; i < 8; i++) e.led[i] = !(ph < int'(mact[i]));
        e.fs    = (cyc > 0) && (cyc % FRAME == 0);
        e.ready = !rst && (cyc % FRAME != FRAME - 1);
        return e;
    endfunction

    task automatic tick_cycle(input logic r, input logic v, input logic [2:0] ch, input logic [7:0] d);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        rst      = r;
        wr_valid = v;
        wr_chan  = ch;
        wr_duty  = d;
        sb_q.push_back(model_expect());
        @(negedge clk);
        e = sb_q.pop_front();
        check("led", int'(led), int'(e.led));
        check("frame_start", int'(frame_start), int'(e.fs));
        check("wr_ready", int'(wr_ready), int'(e.ready));
    endtask

    task automatic idle();
        tick_cycle(1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic count_lit();
        for (int i = 0; i < 8; i++) if (led[i] == 1'b0) lit_cnt[i]++;
    endtask

    // Idles until frame_start; counts lit cycles on the way (excluding the frame_start cycle).
    task automatic wait_frame();
        for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
        ncyc = 0;
        while (1) begin
            idle();
            ncyc++;
            if (frame_start) break;
            if (ncyc > 2100) begin
                check("frame_start_timeout", ncyc, 0);
                break;
            end
            count_lit();
        end
    endtask

    // Called in a frame_start cycle; counts one full frame, ending in the commit cycle.
    task automatic run_frame();
        for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
        count_lit();
        for (int k = 1; k < FRAME; k++) begin
            idle();
            count_lit();
        end
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [7:0] d, output int st);
        st = 0;
        for (int k = 0; k < 10; k++) begin
            tick_cycle(1'b0, 1'b1, ch, d);
            if (wr_ready) return;
            st++;
        end
        check("write_accept_timeout", st, 0);
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_chan  = '0;
        wr_duty  = '0;
        cyc      = 0;
        mdirty   = '0;
        for (int i = 0; i < 8; i++) begin
            mpend[i] = '0;
            mact[i]  = '0;
        end
        vecs[0] = '{ch: 0, duty: 0,   exp_lit: 0};
        vecs[1] = '{ch: 7, duty: 255, exp_lit: 1020};
        vecs[2] = '{ch: 1, duty: 1,   exp_lit: 4};
        vecs[3] = '{ch: 3, duty: 128, exp_lit: 512};
        vecs[4] = '{ch: 4, duty: 17,  exp_lit: 68};
        vecs[5] = '{ch: 6, duty: 254, exp_lit: 1016};
        vecs[6] = '{ch: 2, duty: 0,   exp_lit: 0};

        // Reset, then release; writes offered during reset must be ignored.
        tick_cycle(1'b1, 1'b0, 3'd0, 8'd0);
        tick_cycle(1'b1, 1'b1, 3'd4, 8'd200);
        tick_cycle(1'b1, 1'b0, 3'd0, 8'd0);
        check("reset_led", int'(led), 255);
        check("reset_ready", int'(wr_ready), 0);
        tick_cycle(1'b0, 1'b0, 3'd0, 8'd0);
        check("ready_after_reset", int'(wr_ready), 1);
        check("led_after_reset", int'(led), 255);
        wait_frame();
        check("first_frame_start_latency", ncyc, 1024);
        check("reset_write_ignored", lit_cnt[4], 0);

        // Mid-frame write to chan 2 waits for the next frame.
        repeat (300) idle();
        do_write(3'd2, 8'd64, stalls);
        check("midframe_stalls", stalls, 0);
        wait_frame();
        check("chan2_dark_before_commit", lit_cnt[2], 0);
        run_frame();
        check("chan2_lit_64", lit_cnt[2], 256);
        sum = 0;
        for (int i = 0; i < 8; i++) if (i != 2) sum += lit_cnt[i];
        check("others_dark", sum, 0);

        // Table of channel/duty writes committed together.
        idle();
        foreach (vecs[v]) begin
            do_write(3'(vecs[v].ch), 8'(vecs[v].duty), stalls);
            check("table_stalls", stalls, 0);
        end
        wait_frame();
        run_frame();
        foreach (vecs[v]) check($sformatf("table_lit_ch%0d", vecs[v].ch), lit_cnt[vecs[v].ch], vecs[v].exp_lit);
        check("chan7_dark_steps", FRAME - lit_cnt[7], 4);

        // Write held across the commit cycle stalls once and lands a frame later.
        idle();
        guard = 0;
        while (cyc % FRAME != FRAME - 2 && guard < 2000) begin
            idle();
            guard++;
        end
        do_write(3'd3, 8'd20, stalls);
        check("commit_stall_cycles", stalls, 1);
        check("accept_after_commit_fs", int'(frame_start), 1);
        wait_frame();
        check("chan3_old_duty_kept", lit_cnt[3], 511);
        run_frame();
        check("chan3_new_duty", lit_cnt[3], 80);

        // Last write wins within a frame.
        idle();
        repeat (100) idle();
        do_write(3'd5, 8'd10, stalls);
        repeat (50) idle();
        do_write(3'd5, 8'd200, stalls);
        wait_frame();
        check("chan5_before_commit", lit_cnt[5], 0);
        run_frame();
        check("chan5_last_write", lit_cnt[5], 800);

        // One-cycle reset mid-frame discards dirty pending duties.
        idle();
        repeat (200) idle();
        do_write(3'd1, 8'd99, stalls);
        do_write(3'd6, 8'd33, stalls);
        repeat (10) idle();
        tick_cycle(1'b1, 1'b0, 3'd0, 8'd0);
        tick_cycle(1'b0, 1'b0, 3'd0, 8'd0);
        check("midreset_led", int'(led), 255);
        check("midreset_fs", int'(frame_start), 0);
        check("midreset_ready", int'(wr_ready), 1);
        wait_frame();
        check("midreset_frame_latency", ncyc, 1024);
        run_frame();
        sum = 0;
        for (int i = 0; i < 8; i++) sum += lit_cnt[i];
        check("midreset_all_dark", sum, 0);

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 195, sets the clk_50mhz cycles per PWM step minus one (step period = PRESCALE+1 cycles; about 996 Hz frame rate at the default).
REQ-002 Port clk_50mhz  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port wr_valid  input  1  a duty write is offered this cycle.
REQ-005 Port wr_ready  output  1  the block can accept a write this cycle.
REQ-006 Port wr_chan  input  3  channel index 0..7 of the offered write.
REQ-007 Port wr_duty  input  8  duty value 0..255 of the offered write.
REQ-008 Port led  output  8  LED drive, active-low (0 = lit).
REQ-009 Port frame_start  output  1  one-cycle pulse in the cycle the PWM phase wraps 255->0.

Function
REQ-010 The prescaler shall count 0..PRESCALE and assert an internal tick in the cycle it equals PRESCALE, then return to 0.
REQ-011 The 8-bit phase counter shall increment on each tick and wrap from 255 to 0 with no extra cycle.
REQ-012 Each channel shall hold a pending duty register, an active duty register and a dirty bit.
REQ-013 A write completes when wr_valid and wr_ready are both 1: wr_duty goes to pending[wr_chan] and dirty[wr_chan] is set.
REQ-014 A later write to the same channel before commit shall overwrite pending with no error (last write wins).
REQ-015 Commit occurs in the cycle where tick=1 and phase=255: for every channel with dirty=1, active <= pending and dirty <= 0.
REQ-016 wr_ready shall be 0 exactly in the commit cycle and 1 in every other non-reset cycle, so a write never races a commit.
REQ-017 A write offered during the commit cycle shall stall, complete in the following cycle and take effect at the next frame boundary.
REQ-018 The master shall hold wr_valid, wr_chan and wr_duty stable until the write is accepted.
REQ-019 led[i] is a registered output: led[i] <= ~(phase_next < active_next[i]), where phase_next and active_next are the values phase and active take on the same clock edge (the post-commit values in a commit cycle).
REQ-020 Visible lamp latency shall be one cycle after a phase change, and no duty change shall affect led mid-frame.
REQ-021 Duty 0 shall keep the LED dark (led[i]=1) for the whole frame.
REQ-022 Duty 255 shall light the LED for 255 of 256 steps.
REQ-023 Duty N shall light the LED for exactly N steps per frame, starting at phase 0.
REQ-024 frame_start shall be registered and asserted in the cycle after the commit cycle, aligned with phase first reading 0.

Reset
REQ-025 While rst=1: prescaler=0, phase=0, all pending=0, all active=0, all dirty=0, led=8'hFF, frame_start=0, wr_ready=0.
REQ-026 Writes offered during reset shall be ignored.
REQ-027 Reset asserted mid-frame or in a commit cycle shall win over tick, commit and write.
REQ-028 wr_ready shall rise in the first cycle after rst deasserts.

Structure
REQ-029 A shared package led_pkg shall hold NUM_LEDS=8, DUTY_W=8, CHAN_W=3 and the default PRESCALE constant.
REQ-030 The prescaler plus phase counter shall be one sub-module, pwm_timebase, outputting tick, phase and wrap.
REQ-031 Duty storage, the write handshake, comparators and the output register shall live in led_pwm_driver.

Verification (PRESCALE=3 for sim)
REQ-032 Reset release: led=8'hFF, wr_ready=1 at the first post-reset cycle, and the first frame_start occurs 1024 cycles later.
REQ-033 Write chan 2 duty 64 mid-frame: led[2] stays 1 until the next frame_start, then reads 0 for exactly 64*4 cycles per frame, and other LEDs stay 1.
REQ-034 Write chan 0 duty 0 and chan 7 duty 255: led[0] is never 0, and led[7] reads 1 only during phase 255 (4 cycles per frame).
REQ-035 Hold wr_valid across the commit cycle: wr_ready=0 for exactly that cycle, the write is accepted the next cycle, and it applies one frame later.
REQ-036 Write chan 5 duty 10 then duty 200 within one frame: the next frame shows duty 200 only.
REQ-037 Assert rst for one cycle mid-frame with dirty channels: all outputs return to reset values and no pending duty is ever applied.
